// File: rtl/spi_target_regfile.sv
// 3-wire SPI target with a small 8-bit register file. SPI traffic is
// oversampled in clk; the host side reads the registers combinationally.
module spi_target_regfile #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  inout  wire         sdio,
  input  logic        csb,
  input  logic [7:0]  host_addr,
  output logic [7:0]  host_rdata,
  output logic        wr_strobe,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_done
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {IDLE, INSTR, WRITE, READ, DONE} state_t;

  state_t      state;
  logic [1:0]  sclk_sync, csb_sync, sdio_sync;
  logic        sclk_d, csb_d;
  logic        sclk_rise, sclk_fall, csb_fall, csb_high, sdio_in;
  logic [7:0]  regs [NUM_REGS];
  logic [14:0] instr_sr;
  logic [3:0]  instr_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  tx_sr;
  logic [12:0] addr;
  logic [1:0]  bytes_left;
  logic        need_load;
  logic        oe;
  logic        addr_ok;
  logic [7:0]  spi_rdata;

  // csb synchronizer resets low so a csb held low through reset is not
  // mistaken for a new frame; only a high-then-low sequence starts one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      csb_sync  <= '0;
      sdio_sync <= '0;
      sclk_d    <= 1'b0;
      csb_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      csb_sync  <= {csb_sync[0], csb};
      sdio_sync <= {sdio_sync[0], sdio};
      sclk_d    <= sclk_sync[1];
      csb_d     <= csb_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign csb_fall  = csb_d & ~csb_sync[1];
  assign csb_high  = csb_sync[1];
  assign sdio_in   = sdio_sync[1];

  assign sdio = oe ? tx_sr[7] : 1'bz;

  assign addr_ok = addr < 13'(NUM_REGS);

  always_comb begin
    spi_rdata = '0;
    if (addr_ok) spi_rdata = regs[addr[AW-1:0]];
  end

  always_comb begin
    host_rdata = '0;
    if ({1'b0, host_addr} < 9'(NUM_REGS)) host_rdata = regs[host_addr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      instr_sr   <= '0;
      instr_cnt  <= '0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      addr       <= '0;
      bytes_left <= '0;
      need_load  <= 1'b0;
      oe         <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe  <= 1'b0;
      frame_done <= 1'b0;
      if (csb_high) begin
        state <= IDLE;
        oe    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (csb_fall) begin
              state     <= INSTR;
              instr_cnt <= '0;
            end
          end
          INSTR: begin
            if (sclk_rise) begin
              instr_sr  <= {instr_sr[13:0], sdio_in};
              instr_cnt <= instr_cnt + 4'd1;
              if (instr_cnt == 4'd15) begin
                bytes_left <= instr_sr[13:12];
                addr       <= {instr_sr[11:0], sdio_in};
                bit_cnt    <= '0;
                need_load  <= 1'b1;
                state      <= instr_sr[14] ? READ : WRITE;
              end
            end
          end
          WRITE: begin
            if (sclk_rise) begin
              rx_sr   <= {rx_sr[5:0], sdio_in};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
                wr_data   <= {rx_sr, sdio_in};
                if (addr_ok) regs[addr[AW-1:0]] <= {rx_sr, sdio_in};
                addr <= addr + 13'd1;
                if (bytes_left == 2'd0) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
                end else begin
                  bytes_left <= bytes_left - 2'd1;
                end
              end
            end
          end
          READ: begin
            // A byte boundary only arms need_load; the reload itself waits
            // for the following fall so the last bit stays valid at its rise.
            if (sclk_fall) begin
              if (need_load) begin
                tx_sr     <= spi_rdata;
                oe        <= 1'b1;
                need_load <= 1'b0;
              end else begin
                tx_sr <= {tx_sr[6:0], 1'b0};
              end
            end else if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr      <= addr + 13'd1;
                need_load <= 1'b1;
                if (bytes_left == 2'd0) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
                end else begin
                  bytes_left <= bytes_left - 2'd1;
                end
              end
            end
          end
          DONE: begin
            if (sclk_fall) oe <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_target_regfile.sv
// Randomized SPI frames against a register-array reference model, plus the
// directed write/burst/read/abort/wrap/reset scenarios.
`timescale 1ns/1ps
module tb_spi_target_regfile;

  localparam int HALF = 80;

  logic        clk, reset, sclk, csb;
  logic [7:0]  host_addr;
  logic [7:0]  host_rdata;
  logic        wr_strobe, frame_done;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        drv_en, drv_bit;
  wire         sdio;

  assign sdio = drv_en ? drv_bit : 1'bz;
  pullup (sdio);

  spi_target_regfile #(.NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sdio(sdio), .csb(csb),
    .host_addr(host_addr), .host_rdata(host_rdata), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;
  logic [12:0] obs_addr [$];
  logic [7:0]  obs_data [$];
  logic [7:0]  mem [16];
  logic [7:0]  data_buf [4];

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_strobe) begin
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
      end
      if (frame_done) fd_count++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [12:0] a);
    return (a < 13'd16) ? mem[a[3:0]] : 8'h00;
  endfunction

  task automatic send_bit(input logic b);
    drv_en = 1'b1;
    drv_bit = b;
    #HALF sclk = 1'b1;
    #HALF sclk = 1'b0;
  endtask

  task automatic send_instr(input logic rw, input logic [1:0] w, input logic [12:0] a);
    logic [15:0] ins;
    ins = {rw, w, a};
    for (int i = 15; i >= 0; i--) send_bit(ins[i]);
  endtask

  task automatic start_frame();
    obs_addr.delete();
    obs_data.delete();
    fd_count = 0;
    drv_en = 1'b0;
    csb = 1'b0;
    #HALF;
  endtask

  task automatic end_frame();
    drv_en = 1'b0;
    #HALF csb = 1'b1;
    #(2*HALF);
  endtask

  task automatic write_frame(input logic [12:0] a, input logic [1:0] w);
    logic [12:0] ea;
    start_frame();
    send_instr(1'b0, w, a);
    for (int i = 0; i <= int'(w); i++)
      for (int b = 7; b >= 0; b--) send_bit(data_buf[i][b]);
    end_frame();
    check_eq("wr_count", obs_addr.size(), int'(w) + 1);
    for (int i = 0; i <= int'(w) && i < obs_addr.size(); i++) begin
      ea = a + 13'(i);
      check_eq("wr_addr", obs_addr[i], ea);
      check_eq("wr_data", obs_data[i], data_buf[i]);
      if (ea < 13'd16) mem[ea[3:0]] = data_buf[i];
    end
    check_eq("wr_frame_done", fd_count, 1);
  endtask

  task automatic read_frame(input logic [12:0] a, input logic [1:0] w);
    logic [15:0] ins;
    logic [7:0]  got;
    ins = {1'b1, w, a};
    start_frame();
    check_eq("rd_idle_z", sdio, 1'b1);
    for (int i = 15; i >= 1; i--) send_bit(ins[i]);
    drv_bit = ins[0];
    #HALF sclk = 1'b1;
    #HALF sclk = 1'b0;
    drv_en = 1'b0;
    #1 check_eq("rd_pre_z", sdio, 1'b1);
    #(HALF-1);
    for (int i = 0; i <= int'(w); i++) begin
      got = '0;
      for (int b = 7; b >= 0; b--) begin
        got = {got[6:0], sdio};
        sclk = 1'b1;
        #HALF sclk = 1'b0;
        #HALF;
      end
      check_eq("rd_byte", got, model_rd(a + 13'(i)));
    end
    check_eq("rd_post_z", sdio, 1'b1);
    csb = 1'b1;
    #(2*HALF);
    check_eq("rd_frame_done", fd_count, 1);
    check_eq("rd_no_strobe", obs_addr.size(), 0);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      host_addr = 8'(i);
      #10 check_eq(tag, host_rdata, mem[i]);
    end
  endtask

  initial begin
    logic [12:0] ra;
    logic [1:0]  rw_w;
    reset = 1'b1; csb = 1'b1; sclk = 1'b0; drv_en = 1'b0; drv_bit = 1'b0;
    host_addr = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    #33 reset = 1'b0;
    #20;
    check_eq("rst_strobe", wr_strobe, 1'b0);
    check_eq("rst_addr", wr_addr, 13'h0);
    check_eq("rst_data", wr_data, 8'h00);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_sdio_z", sdio, 1'b1);
    check_all_regs("rst_reg");
    host_addr = 8'd200;
    #10 check_eq("host_oor", host_rdata, 8'h00);

    data_buf[0] = 8'hA5;
    write_frame(13'h003, 2'd0);
    host_addr = 8'd3;
    #10 check_eq("host_reg3", host_rdata, 8'hA5);

    data_buf[0] = 8'h11; data_buf[1] = 8'h22; data_buf[2] = 8'h33; data_buf[3] = 8'h44;
    write_frame(13'h00E, 2'd3);
    host_addr = 8'd14;
    #10 check_eq("burst_reg14", host_rdata, 8'h11);
    host_addr = 8'd15;
    #10 check_eq("burst_reg15", host_rdata, 8'h22);

    data_buf[0] = 8'h5A;
    write_frame(13'h004, 2'd0);
    read_frame(13'h003, 2'd1);

    start_frame();
    send_instr(1'b0, 2'd0, 13'h002);
    for (int b = 0; b < 5; b++) send_bit(b[0]);
    drv_en = 1'b0;
    csb = 1'b1;
    #(2*HALF);
    check_eq("abort_strobe", obs_addr.size(), 0);
    check_eq("abort_done", fd_count, 0);
    host_addr = 8'd2;
    #10 check_eq("abort_reg2", host_rdata, mem[2]);
    data_buf[0] = 8'h7C;
    write_frame(13'h002, 2'd0);

    data_buf[0] = 8'h01; data_buf[1] = 8'h02;
    write_frame(13'h1FFF, 2'd1);
    host_addr = 8'd0;
    #10 check_eq("wrap_reg0", host_rdata, 8'h02);

    for (int n = 0; n < 12; n++) begin
      rw_w = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ra = 13'h1FFD + 13'($urandom_range(0, 2));
      else ra = 13'($urandom_range(0, 19));
      for (int i = 0; i < 4; i++) data_buf[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) read_frame(ra, rw_w);
      else write_frame(ra, rw_w);
    end
    check_all_regs("rand_reg");

    data_buf[0] = 8'hA5;
    write_frame(13'h003, 2'd0);
    start_frame();
    send_instr(1'b1, 2'd0, 13'h003);
    drv_en = 1'b0;
    #HALF sclk = 1'b1;
    #HALF sclk = 1'b0;
    #HALF;
    check_eq("rst_rd_driving", sdio, 1'b0);
    reset = 1'b1;
    #1 check_eq("rst_rd_z", sdio, 1'b1);
    #9;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    check_all_regs("rst_rd_reg");
    reset = 1'b0;
    #20;
    for (int b = 0; b < 10; b++) send_bit(1'b0);
    drv_en = 1'b0;
    #HALF;
    check_eq("rst_rd_no_strobe", obs_addr.size(), 0);
    check_eq("rst_rd_no_done", fd_count, 0);
    csb = 1'b1;
    #(2*HALF);
    data_buf[0] = 8'h3C;
    write_frame(13'h005, 2'd0);
    check_all_regs("final_reg");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
